spi_slave_serdes: RTL
=====================

// Module: spi_slave_serdes
// PURPOSE
//  SPI mode-0 target-side PHY feeding the flash emulation command stage. Synchronises the raw
//  SCLK/CS_n/MOSI pins into clk, deserialises MOSI into bytes with start-of-transaction marking,
//  and serialises one response byte per SPI byte onto MISO. It owns all pin timing; downstream
//  logic sees only single-cycle byte strobes in the clk domain.
// PARAMETERS
//  SYNC_STAGES   2      flops per pin synchroniser (>=2)
//  TX_IDLE_BYTE  8'hFF  byte shifted out when no response byte is loaded
// PORTS
//  clk            in   1  system clock, >= 6x SCLK frequency
//  reset          in   1  synchronous, active-high
//  pin_sclk       in   1  raw SPI clock, async
//  pin_cs_n       in   1  raw chip select, active-low, async
//  pin_mosi       in   1  raw controller data out, async
//  pin_miso       out  1  target data out
//  pin_miso_oe    out  1  1 = drive pin_miso (CS asserted)
//  spi_cs         out  1  synchronised CS_n level; 1 = deselected
//  spi_rx_data    out  8  last complete received byte, MSB first on the wire
//  spi_rx_cmd     out  1  1-cycle pulse with spi_rx_strobe for first byte after CS assert
//  spi_rx_strobe  out  1  1-cycle pulse: spi_rx_data holds a new byte
//  spi_tx_strobe  in   1  1-cycle pulse: load spi_tx_data as next response byte
//  spi_tx_data    in   8  response byte
//  tx_underrun    out  1  1-cycle pulse: byte boundary reached with no response loaded
//  tx_overrun     out  1  1-cycle pulse: spi_tx_strobe while holding register already full
// BEHAVIOUR
//  Reset values: pin_miso=1, pin_miso_oe=0, spi_cs=1, spi_rx_data=0, all pulses 0; synchronisers
//   preset to sclk=0, cs_n=1; bit_cnt=0, first=1, hold_valid=0, tx_shift=TX_IDLE_BYTE.
//  Sync: each pin through SYNC_STAGES flops; edges taken from last stage vs. one extra delay flop.
//   sclk_rise/sclk_fall/cs_fall/cs_rise are 1-cycle pulses; pin-to-event latency SYNC_STAGES+1 clk.
//  States: IDLE (spi_cs=1) and ACTIVE (spi_cs=0). IDLE->ACTIVE on cs_fall; ACTIVE->IDLE on cs_rise.
//  IDLE: bit_cnt=0, first=1, SCLK edges ignored, pin_miso_oe=0, rx strobes never fire.
//  cs_fall: tx_shift <= hold_valid ? hold : TX_IDLE_BYTE (clears hold_valid, no underrun pulse).
//  RX (ACTIVE, sclk_rise): rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt <= bit_cnt+1 (3-bit wrap).
//   When bit_cnt==7 at rise: next cycle spi_rx_data = completed byte, spi_rx_strobe=1,
//   spi_rx_cmd=first; first <= 0. spi_rx_data holds until the next completed byte.
//  TX: pin_miso = tx_shift[7]; pin_miso_oe = !spi_cs.
//   sclk_fall with bit_cnt!=0: tx_shift <= {tx_shift[6:0],1'b1}.
//   sclk_fall with bit_cnt==0 (byte boundary): tx_shift <= hold_valid ? hold : TX_IDLE_BYTE;
//   hold_valid <= 0; if !hold_valid, tx_underrun pulse. Skipped on the first fall of a transaction
//   only if no rise has occurred yet (spurious fall).
//  Holding register: spi_tx_strobe loads hold, sets hold_valid. Already valid -> overwrite, tx_overrun.
//   Strobe on the same cycle as a boundary load: spi_tx_data bypasses hold into tx_shift, no
//   underrun, hold_valid stays 0.
//  cs_rise mid-byte: partial bits discarded, no strobe; bit_cnt=0, first=1; hold_valid kept.
//  cs_rise and sclk edge same cycle: CS wins, edge ignored.
//  Reset mid-transaction: all state to reset values; reacquires on the next cs_fall only.
// STRUCTURE
//  Package spi_pkg: SPI_BYTE_W=8, SPI_IDLE_BYTE=8'hFF, spi_state_t enum {SPI_IDLE, SPI_ACTIVE}.
//  Sub-module spi_pin_sync: SYNC_STAGES synchroniser + rise/fall pulse outputs, one instance per
//  pin (sclk, cs_n, mosi; mosi edge outputs unused). Top holds FSM, bit counter, shift/hold regs.
// TESTING
//  CS low, send 0x03,0x12,0x34,0x56 at clk/8 -> 4 rx strobes, data 03/12/34/56, rx_cmd only on 03.
//  tx_strobe 0xA5 after 2nd rx byte -> MISO bits of byte 3 = 1010_0101, byte 4 = FF + tx_underrun.
//  CS rise after 5 bits of byte 2 -> no 2nd strobe; next CS fall byte 0x9F -> strobe with rx_cmd=1.
//  Two tx_strobes (0x11,0x22) in one byte -> tx_overrun once, MISO next byte = 0x22.
//  tx_strobe exactly on boundary-fall cycle -> byte shifted out, no underrun pulse.
//  reset asserted mid-byte -> pin_miso_oe=0, spi_cs=1 next cycle; no strobe until new CS fall.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI target-side PHY.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;

    typedef enum logic {
        SPI_IDLE,
        SPI_ACTIVE
    } spi_state_t;

endpackage

// File: rtl/spi_slave_serdes_if.sv
// Pin-side and byte-side signals of the SPI PHY; slave is the PHY, master is pins plus consumer.
interface spi_slave_serdes_if;
    import spi_pkg::*;

    logic                  pin_sclk;
    logic                  pin_cs_n;
    logic                  pin_mosi;
    logic                  pin_miso;
    logic                  pin_miso_oe;
    logic                  spi_cs;
    logic [SPI_BYTE_W-1:0] spi_rx_data;
    logic                  spi_rx_cmd;
    logic                  spi_rx_strobe;
    logic                  spi_tx_strobe;
    logic [SPI_BYTE_W-1:0] spi_tx_data;
    logic                  tx_underrun;
    logic                  tx_overrun;

    modport slave (
        input  pin_sclk, pin_cs_n, pin_mosi, spi_tx_strobe, spi_tx_data,
        output pin_miso, pin_miso_oe, spi_cs, spi_rx_data, spi_rx_cmd, spi_rx_strobe,
               tx_underrun, tx_overrun
    );

    modport master (
        output pin_sclk, pin_cs_n, pin_mosi, spi_tx_strobe, spi_tx_data,
        input  pin_miso, pin_miso_oe, spi_cs, spi_rx_data, spi_rx_cmd, spi_rx_strobe,
               tx_underrun, tx_overrun
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin with single-cycle edge pulses.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_serdes.sv
// SPI mode-0 target PHY: pin synchronisation, MOSI deserialiser and MISO serialiser with a
// one-byte response holding register.
module spi_slave_serdes
    import spi_pkg::*;
#(
    parameter int unsigned           SYNC_STAGES  = 2,
    parameter logic [SPI_BYTE_W-1:0] TX_IDLE_BYTE = SPI_IDLE_BYTE
) (
    input  logic                     clk,
    input  logic                     reset,
    spi_slave_serdes_if.slave        spi
);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level_unused, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .pin   (spi.pin_sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk   (clk),
        .reset (reset),
        .pin   (spi.pin_cs_n),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .pin   (spi.pin_mosi),
        .level (mosi_sync),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    spi_state_t            state_q;
    logic [2:0]            bit_cnt_q;
    logic                  first_q;
    logic                  rose_q;
    logic [SPI_BYTE_W-2:0] rx_shift_q;
    logic [SPI_BYTE_W-1:0] rx_data_q;
    logic                  rx_strobe_q;
    logic                  rx_cmd_q;
    logic [SPI_BYTE_W-1:0] tx_shift_q;
    logic [SPI_BYTE_W-1:0] hold_q;
    logic                  hold_valid_q;
    logic                  underrun_q;
    logic                  overrun_q;
    logic                  boundary;

    // A fall before any rise in this transaction is spurious and must not consume a byte.
    assign boundary = (state_q == SPI_ACTIVE) && sclk_fall && !cs_rise &&
                      (bit_cnt_q == 3'd0) && rose_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SPI_IDLE;
            bit_cnt_q    <= 3'd0;
            first_q      <= 1'b1;
            rose_q       <= 1'b0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_strobe_q  <= 1'b0;
            rx_cmd_q     <= 1'b0;
            tx_shift_q   <= TX_IDLE_BYTE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_strobe_q <= 1'b0;
            rx_cmd_q    <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            unique case (state_q)
                SPI_IDLE: begin
                    bit_cnt_q <= 3'd0;
                    first_q   <= 1'b1;
                    rose_q    <= 1'b0;
                    if (cs_fall) begin
                        state_q      <= SPI_ACTIVE;
                        hold_valid_q <= 1'b0;
                        if (spi.spi_tx_strobe) begin
                            tx_shift_q <= spi.spi_tx_data;
                        end else if (hold_valid_q) begin
                            tx_shift_q <= hold_q;
                        end else begin
                            tx_shift_q <= TX_IDLE_BYTE;
                        end
                    end else if (spi.spi_tx_strobe) begin
                        hold_q       <= spi.spi_tx_data;
                        hold_valid_q <= 1'b1;
                        overrun_q    <= hold_valid_q;
                    end
                end
                SPI_ACTIVE: begin
                    if (cs_rise) begin
                        state_q   <= SPI_IDLE;
                        bit_cnt_q <= 3'd0;
                        first_q   <= 1'b1;
                        rose_q    <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[SPI_BYTE_W-3:0], mosi_sync};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        rose_q     <= 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q   <= {rx_shift_q, mosi_sync};
                            rx_strobe_q <= 1'b1;
                            rx_cmd_q    <= first_q;
                            first_q     <= 1'b0;
                        end
                    end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                        tx_shift_q <= {tx_shift_q[SPI_BYTE_W-2:0], 1'b1};
                    end

                    // A strobe coinciding with the boundary bypasses the holding register.
                    if (boundary) begin
                        hold_valid_q <= 1'b0;
                        if (spi.spi_tx_strobe) begin
                            tx_shift_q <= spi.spi_tx_data;
                        end else if (hold_valid_q) begin
                            tx_shift_q <= hold_q;
                        end else begin
                            tx_shift_q <= TX_IDLE_BYTE;
                            underrun_q <= 1'b1;
                        end
                    end else if (spi.spi_tx_strobe) begin
                        hold_q       <= spi.spi_tx_data;
                        hold_valid_q <= 1'b1;
                        overrun_q    <= hold_valid_q;
                    end
                end
            endcase
        end
    end

    assign spi.spi_cs        = (state_q == SPI_IDLE);
    assign spi.pin_miso_oe   = (state_q == SPI_ACTIVE);
    assign spi.pin_miso      = tx_shift_q[SPI_BYTE_W-1];
    assign spi.spi_rx_data   = rx_data_q;
    assign spi.spi_rx_strobe = rx_strobe_q;
    assign spi.spi_rx_cmd    = rx_cmd_q;
    assign spi.tx_underrun   = underrun_q;
    assign spi.tx_overrun    = overrun_q;

endmodule
